// File: rtl/mem_responder_if.sv
// Request/response bundle between the traffic processor and mem_responder.
// Signal names mirror the processor bus so both sides read identically.
interface mem_responder_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              RWB;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] Data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wbuf_empty;

  modport master (
    output req_valid, RWB, Address, Data,
    input  req_ready, rd_valid, rd_data, wbuf_empty
  );

  modport slave (
    input  req_valid, RWB, Address, Data,
    output req_ready, rd_valid, rd_data, wbuf_empty
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side bus responder: single-port RAM behind a write-posting FIFO with read forwarding.
// Optional STATS_EN macro adds saturating rd/wr/stall counters.
module mem_responder #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 8,
  parameter int WBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_responder_if.slave bus
`ifdef STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [15:0] stall_count
`endif
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW    = $clog2(WBUF_DEPTH);
  localparam int CW    = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wb_addr_q [WBUF_DEPTH];
  logic [DATA_W-1:0] wb_data_q [WBUF_DEPTH];

  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rd_vld_q;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic full, acc, rd_acc, wr_acc, drain;
  logic [WBUF_DEPTH-1:0] slot_hit;
  logic [PW-1:0]         slot_idx [WBUF_DEPTH];
  logic                  fwd_hit;
  logic [DATA_W-1:0]     fwd_data;

  assign full          = (cnt_q == CW'(WBUF_DEPTH));
  assign bus.req_ready = !full && rst_n;
  assign acc           = bus.req_valid && bus.req_ready;
  assign rd_acc        = acc && bus.RWB;
  assign wr_acc        = acc && !bus.RWB;
  // RAM port is only free when no request is accepted; never drain during reset.
  assign drain         = rst_n && !acc && (cnt_q != '0);

  assign bus.rd_valid   = rd_vld_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.wbuf_empty = (cnt_q == '0);

  // Slot i is the i-th oldest live entry; live only while i < count.
  for (genvar i = 0; i < WBUF_DEPTH; i++) begin : g_fwd
    assign slot_idx[i] = head_q + PW'(i);
    assign slot_hit[i] = (CW'(i) < cnt_q) && (wb_addr_q[slot_idx[i]] == bus.Address);
  end

  // Scan oldest to newest so the newest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (slot_hit[i]) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_q[slot_idx[i]];
      end
    end
  end

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    if (wr_acc) begin
      tail_d = tail_q + 1'b1;
      cnt_d  = cnt_q + 1'b1;
    end else if (drain) begin
      head_d = head_q + 1'b1;
      cnt_d  = cnt_q - 1'b1;
    end
    if (rd_acc) rd_data_d = fwd_hit ? fwd_data : mem[bus.Address];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      rd_vld_q  <= rd_acc;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage arrays carry no reset; live-ness comes from the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      wb_addr_q[tail_q] <= bus.Address;
      wb_data_q[tail_q] <= bus.Data;
    end
    if (drain) mem[wb_addr_q[head_q]] <= wb_data_q[head_q];
  end

`ifdef STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;
  logic        stall;

  assign stall       = bus.req_valid && !bus.req_ready;
  assign rd_count    = rd_cnt_q;
  assign wr_count    = wr_cnt_q;
  assign stall_count = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (rd_acc && (rd_cnt_q != 16'hFFFF))   rd_cnt_q    <= rd_cnt_q + 16'd1;
      if (wr_acc && (wr_cnt_q != 16'hFFFF))   wr_cnt_q    <= wr_cnt_q + 16'd1;
      if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end
`endif
endmodule
